// File: rtl/vector_control_seq_if.sv
// Issue/control bundle between fetch, the vector control sequencer and the datapath.
// The master side drives IDs and memory acks; the slave side is the sequencer.
interface vector_control_seq_if #(
  parameter int LANES          = 4,
  parameter int LANES_PER_BEAT = 1
);
  localparam int BEATS = LANES / LANES_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             id_valid;
  logic [6:0]       Id;
  logic             id_ready;
  logic             mem_ack;
  logic             issue_valid;
  logic             RegWrite;
  logic             MemtoReg;
  logic             MemWrite;
  logic             FlagsWrite;
  logic             RegSrc;
  logic             LDFlag;
  logic [1:0]       VSIFlag;
  logic [2:0]       ALUControl;
  logic [BW-1:0]    LaneSel;
  logic [LANES-1:0] LaneMask;
  logic             halted;

  modport master (
    output id_valid, Id, mem_ack,
    input  id_ready, issue_valid, RegWrite, MemtoReg, MemWrite, FlagsWrite,
           RegSrc, LDFlag, VSIFlag, ALUControl, LaneSel, LaneMask, halted
  );

  modport slave (
    input  id_valid, Id, mem_ack,
    output id_ready, issue_valid, RegWrite, MemtoReg, MemWrite, FlagsWrite,
           RegSrc, LDFlag, VSIFlag, ALUControl, LaneSel, LaneMask, halted
  );
endinterface

// File: rtl/vector_control_seq.sv
// Sequenced vector control unit: accepts 7-bit instruction IDs and drives registered
// datapath controls for one cycle, or one cycle per lane beat for memory instructions.
module vector_control_seq #(
  parameter int LANES          = 4,
  parameter int LANES_PER_BEAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_control_seq_if.slave  bus
);
  localparam int BEATS = LANES / LANES_PER_BEAT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] CMP_OP  = 3'b100;
  localparam logic [6:0] HALT_ID = 7'b0011111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  if (LANES_PER_BEAT < 1 || (LANES % LANES_PER_BEAT) != 0) begin : gBadLanes
    $error("vector_control_seq: LANES_PER_BEAT must divide LANES");
  end

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memWrite;
    logic       flagsWrite;
    logic       regSrc;
    logic       ldFlag;
    logic [1:0] vsiFlag;
    logic [2:0] aluCtl;
  } ctl_t;

  logic [1:0]       state;
  logic [BW-1:0]    beatCnt;
  ctl_t             ctlQ;
  ctl_t             ctlD;
  ctl_t             ctlOut;
  logic             idReady;
  logic             accept;
  logic             lastBeat;
  logic             issue;
  logic [LANES-1:0] beatMask;

  assign idReady  = (state == S_IDLE) | (state == S_EXEC);
  assign accept   = bus.id_valid & idReady;
  assign lastBeat = (beatCnt == BW'(BEATS - 1));
  assign issue    = (state == S_EXEC) | (state == S_MEM);

  always_comb begin
    ctlD        = '0;
    ctlD.aluCtl = bus.Id[4:2];
    case (bus.Id[6:5])
      2'b01: begin
        ctlD.flagsWrite = (bus.Id[4:2] == CMP_OP);
        ctlD.regWrite   = (bus.Id[4:2] != CMP_OP);
        ctlD.vsiFlag    = bus.Id[1:0];
      end
      2'b10: begin
        ctlD.memWrite = bus.Id[4];
        ctlD.regSrc   = bus.Id[4];
        ctlD.regWrite = ~bus.Id[4];
        ctlD.memtoReg = ~bus.Id[4];
        ctlD.ldFlag   = 1'b1;
        ctlD.vsiFlag  = bus.Id[1:0];
        ctlD.aluCtl   = 3'b000;
      end
      default: ;
    endcase
  end

  // An EXEC cycle without a new accept falls back to IDLE; MEM only advances on mem_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      beatCnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_EXEC: begin
          if (accept) begin
            if (bus.Id == HALT_ID) begin
              state <= S_HALT;
            end else if (bus.Id[6:5] == 2'b10) begin
              state   <= S_MEM;
              beatCnt <= '0;
            end else begin
              state <= S_EXEC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (lastBeat) begin
              state   <= S_IDLE;
              beatCnt <= '0;
            end else begin
              beatCnt <= beatCnt + BW'(1);
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctlQ <= '0;
    end else if (accept) begin
      ctlQ <= ctlD;
    end
  end

  // Lane i belongs to beat i / LANES_PER_BEAT.
  always_comb begin
    beatMask = '0;
    for (int i = 0; i < LANES; i++) begin
      beatMask[i] = ((i / LANES_PER_BEAT) == int'(beatCnt));
    end
  end

  assign ctlOut = issue ? ctlQ : '0;

  assign bus.id_ready    = idReady;
  assign bus.issue_valid = issue;
  assign bus.RegWrite    = ctlOut.regWrite;
  assign bus.MemtoReg    = ctlOut.memtoReg;
  assign bus.MemWrite    = ctlOut.memWrite;
  assign bus.FlagsWrite  = ctlOut.flagsWrite;
  assign bus.RegSrc      = ctlOut.regSrc;
  assign bus.LDFlag      = ctlOut.ldFlag;
  assign bus.VSIFlag     = ctlOut.vsiFlag;
  assign bus.ALUControl  = ctlOut.aluCtl;
  assign bus.LaneSel     = (state == S_MEM) ? beatCnt : '0;
  assign bus.LaneMask    = (state == S_EXEC) ? '1 : ((state == S_MEM) ? beatMask : '0);
  assign bus.halted      = (state == S_HALT);
endmodule

// File: tb/tb_vector_control_seq.sv
// Bench for vector_control_seq: two instances (LANES=4 with 1 and 2 lanes per beat)
// share directed and random stimulus and are compared against an instruction-level model.
module tb_vector_control_seq;
  localparam logic [2:0] CMP_OP  = 3'b100;
  localparam logic [6:0] HALT_ID = 7'b0011111;
  localparam logic [6:0] LDR_ID  = 7'b1000001;
  localparam logic [6:0] STR_ID  = 7'b1010000;
  localparam logic [6:0] ADD_ID  = 7'b0100011;
  localparam logic [6:0] CMP_ID  = {2'b01, CMP_OP, 2'b00};

  localparam int M_IDLE = 0;
  localparam int M_EXEC = 1;
  localparam int M_MEM  = 2;
  localparam int M_HALT = 3;

  typedef struct packed {
    logic       idr, iv, rw, m2r, mw, fw, rs, ld, halt;
    logic [1:0] vsi;
    logic [2:0] alu;
    logic [1:0] sel;
    logic [3:0] mask;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idValid;
  logic [6:0] idVal;
  logic       memAck;
  int         checks = 0;
  int         failures = 0;

  int         mMode [2];
  int         mBeat [2];
  logic [6:0] mId   [2];

  outs_t obs0, obs1;

  always #5 clk = ~clk;

  vector_control_seq_if #(.LANES(4), .LANES_PER_BEAT(1)) bus0 ();
  vector_control_seq_if #(.LANES(4), .LANES_PER_BEAT(2)) bus1 ();

  vector_control_seq #(.LANES(4), .LANES_PER_BEAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  vector_control_seq #(.LANES(4), .LANES_PER_BEAT(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.id_valid = idValid;
  assign bus0.Id       = idVal;
  assign bus0.mem_ack  = memAck;
  assign bus1.id_valid = idValid;
  assign bus1.Id       = idVal;
  assign bus1.mem_ack  = memAck;

  assign obs0 = {bus0.id_ready, bus0.issue_valid, bus0.RegWrite, bus0.MemtoReg, bus0.MemWrite,
                 bus0.FlagsWrite, bus0.RegSrc, bus0.LDFlag, bus0.halted, bus0.VSIFlag,
                 bus0.ALUControl, bus0.LaneSel, bus0.LaneMask};
  assign obs1 = {bus1.id_ready, bus1.issue_valid, bus1.RegWrite, bus1.MemtoReg, bus1.MemWrite,
                 bus1.FlagsWrite, bus1.RegSrc, bus1.LDFlag, bus1.halted, bus1.VSIFlag,
                 bus1.ALUControl, 1'b0, bus1.LaneSel, bus1.LaneMask};

  // Expected outputs derived from the instruction currently being issued.
  function automatic outs_t modelOut(input int k);
    outs_t      e;
    logic [2:0] op;
    int         lpb;
    e   = '0;
    op  = mId[k][4:2];
    lpb = k + 1;
    e.idr  = (mMode[k] == M_IDLE) || (mMode[k] == M_EXEC);
    e.halt = (mMode[k] == M_HALT);
    e.iv   = (mMode[k] == M_EXEC) || (mMode[k] == M_MEM);
    if (e.iv) begin
      case (mId[k][6:5])
        2'b01: begin
          e.fw  = (op == CMP_OP);
          e.rw  = (op != CMP_OP);
          e.vsi = mId[k][1:0];
          e.alu = op;
        end
        2'b10: begin
          e.mw  = mId[k][4];
          e.rs  = mId[k][4];
          e.rw  = !mId[k][4];
          e.m2r = !mId[k][4];
          e.ld  = 1'b1;
          e.vsi = mId[k][1:0];
        end
        default: e.alu = op;
      endcase
      if (mMode[k] == M_EXEC) begin
        e.mask = 4'b1111;
      end else begin
        for (int i = 0; i < 4; i++) e.mask[i] = ((i / lpb) == mBeat[k]);
        e.sel = 2'(mBeat[k]);
      end
    end
    return e;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mMode[k] = M_IDLE;
      mBeat[k] = 0;
      mId[k]   = 7'd0;
    end
  endtask

  task automatic modelEdge(input logic v, input logic [6:0] id, input logic ack);
    for (int k = 0; k < 2; k++) begin
      int beats = 4 / (k + 1);
      if (mMode[k] == M_MEM) begin
        if (ack) begin
          if (mBeat[k] == beats - 1) begin
            mMode[k] = M_IDLE;
            mBeat[k] = 0;
          end else begin
            mBeat[k] = mBeat[k] + 1;
          end
        end
      end else if (mMode[k] != M_HALT) begin
        if (v) begin
          mId[k] = id;
          if (id == HALT_ID) mMode[k] = M_HALT;
          else if (id[6:5] == 2'b10) begin
            mMode[k] = M_MEM;
            mBeat[k] = 0;
          end else mMode[k] = M_EXEC;
        end else begin
          mMode[k] = M_IDLE;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    outs_t observed, expected;
    for (int k = 0; k < 2; k++) begin
      observed = (k == 0) ? obs0 : obs1;
      expected = modelOut(k);
      checks++;
      assert (observed === expected) else begin
        failures++;
        $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, k, observed, expected);
      end
    end
  endtask

  // Called just after an active edge: drive, clock once, update model, then compare.
  task automatic applyStimulus(input logic v, input logic [6:0] id, input logic ack, input string tag);
    idValid = v;
    idVal   = id;
    memAck  = ack;
    @(posedge clk);
    modelEdge(v, id, ack);
    #1;
    checkOutput(tag);
  endtask

  task automatic asyncReset(input string tag);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic       rv, ra;
    logic [6:0] rid;
    rst_n   = 1'b1;
    idValid = 1'b0;
    idVal   = 7'd0;
    memAck  = 1'b0;
    modelReset();
    #1 rst_n = 1'b0;
    #1 checkOutput("reset_async");
    @(posedge clk);
    #1 checkOutput("reset_held");
    rst_n = 1'b1;

    $display("[TB] LDR with back-to-back acks");
    applyStimulus(1'b1, LDR_ID, 1'b0, "ldr_accept");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 7'd0, 1'b1, "ldr_beat");
    applyStimulus(1'b0, 7'd0, 1'b0, "ldr_idle");

    $display("[TB] STR with withheld acks");
    applyStimulus(1'b1, STR_ID, 1'b0, "str_accept");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADD_ID, 1'b0, "str_hold");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 7'd0, 1'b1, "str_beat");
    applyStimulus(1'b0, 7'd0, 1'b0, "str_idle");

    $display("[TB] back-to-back data processing");
    applyStimulus(1'b1, ADD_ID, 1'b0, "dp_add");
    applyStimulus(1'b1, CMP_ID, 1'b0, "dp_cmp");
    applyStimulus(1'b0, 7'd0, 1'b0, "dp_idle");

    $display("[TB] control and NOP with stray acks");
    applyStimulus(1'b1, 7'b1101100, 1'b1, "ctl_issue");
    applyStimulus(1'b1, 7'b0000000, 1'b1, "nop_issue");
    applyStimulus(1'b0, 7'd0, 1'b1, "nop_idle");

    $display("[TB] reset mid LDR");
    applyStimulus(1'b1, LDR_ID, 1'b0, "rst_ldr_accept");
    applyStimulus(1'b0, 7'd0, 1'b1, "rst_ldr_b1");
    applyStimulus(1'b0, 7'd0, 1'b1, "rst_ldr_b2");
    asyncReset("rst_mid_mem");
    applyStimulus(1'b1, ADD_ID, 1'b0, "rst_after_accept");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rid = 7'($urandom_range(0, 127));
      if (rid == HALT_ID) rid = 7'b0011110;
      ra  = $urandom_range(0, 1) == 1;
      applyStimulus(rv, rid, ra, "random");
    end
    applyStimulus(1'b0, 7'd0, 1'b1, "random_drain");
    applyStimulus(1'b0, 7'd0, 1'b1, "random_drain");
    applyStimulus(1'b0, 7'd0, 1'b1, "random_drain");
    applyStimulus(1'b0, 7'd0, 1'b1, "random_drain");
    applyStimulus(1'b0, 7'd0, 1'b0, "random_drain");

    $display("[TB] HALT is sticky");
    applyStimulus(1'b1, HALT_ID, 1'b0, "halt_accept");
    applyStimulus(1'b1, ADD_ID, 1'b0, "halt_ignore_add");
    applyStimulus(1'b1, LDR_ID, 1'b1, "halt_ignore_ldr");
    applyStimulus(1'b1, 7'b1101100, 1'b0, "halt_ignore_ctl");
    asyncReset("halt_reset");
    applyStimulus(1'b1, CMP_ID, 1'b0, "halt_recover");
    applyStimulus(1'b0, 7'd0, 1'b0, "halt_recover_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
